// File: rtl/godai_mem_pkg.sv
// rtl/godai_mem_pkg.sv - shared types and constants for the instruction memory responder
// Purpose: response record carried through the read delay line, latency ceiling and default boot address.
package godai_mem_pkg;

  localparam int          MAX_LATENCY       = 8;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_8000;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } mem_resp_t;

endpackage

// File: rtl/mem_resp_pipe.sv
// rtl/mem_resp_pipe.sv - LATENCY-deep delay line for fetch responses
// Purpose: delays a mem_resp_t by exactly LATENCY clock edges.
// Ports:
//   clk_i   in   clock
//   rst_i   in   asynchronous active-high clear of every stage
//   resp_i  in   response entering the line (valid marks a granted fetch)
//   resp_o  out  response leaving the line
module mem_resp_pipe
  import godai_mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  mem_resp_t resp_i,
  output mem_resp_t resp_o
);

  mem_resp_t stage_q [LATENCY];
  mem_resp_t src     [LATENCY];

  always_comb begin
    src[0] = resp_i;
    for (int i = 1; i < LATENCY; i++) begin
      src[i] = stage_q[i-1];
    end
  end

  // valid shifts every edge; data/err only move with a valid entry, so the
  // last stage keeps the most recent response across bubbles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i].valid <= src[i].valid;
        if (src[i].valid) begin
          stage_q[i].err  <= src[i].err;
          stage_q[i].data <= src[i].data;
        end
      end
    end
  end

  assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - instruction-side memory slave for the core fetch port
// Purpose: word storage with preload, fixed-latency in-order read responses,
//   bounded outstanding requests and an optional periodic grant stall.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   instr_req_i/instr_addr_i     fetch request and byte address (bits [1:0] ignored)
//   instr_gnt_o                  combinational grant
//   instr_rvalid_o/rdata_o/err_o response; rdata/err hold when rvalid is low
//   load_we_i/addr_i/wdata_i     preload write port (word index)
//   busy_o                       outstanding count non-zero
module instr_mem_responder
  import godai_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    MEM_WORDS       = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int                    LATENCY         = 1,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter int                    STALL_PERIOD    = 0,
  parameter logic [DATA_WIDTH-1:0] ERR_WORD        = 32'hDEAD_BEEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         instr_req_i,
  input  logic [ADDR_WIDTH-1:0]        instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]        instr_rdata_o,
  output logic                         instr_err_o,
  input  logic                         load_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0]        load_wdata_i,
  output logic                         busy_o
);

  localparam int                    IW     = $clog2(MEM_WORDS);
  localparam int                    CW     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]         MAX_Q  = CW'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] DEPTH  = ADDR_WIDTH'(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [CW-1:0]         out_q, out_d;
  logic                  busy_q;
  logic                  stall_cycle;
  logic [ADDR_WIDTH:0]   offset;
  logic [ADDR_WIDTH-1:0] word_off;
  logic                  in_range;
  mem_resp_t             resp_in, resp_out;

  // One extra bit so addresses below BASE_ADDR show up as a borrow.
  assign offset   = {1'b0, instr_addr_i} - {1'b0, BASE_ADDR};
  assign word_off = offset[ADDR_WIDTH-1:0] >> 2;
  assign in_range = !offset[ADDR_WIDTH] && (word_off < DEPTH);

  assign instr_gnt_o = instr_req_i && !rst_i && (out_q < MAX_Q) && !stall_cycle;

  generate
    if (STALL_PERIOD == 0) begin : g_no_stall
      assign stall_cycle = 1'b0;
    end else begin : g_stall
      localparam int            SW   = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
      localparam logic [SW-1:0] LAST = SW'(STALL_PERIOD - 1);
      logic [SW-1:0] stall_cnt_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                    stall_cnt_q <= '0;
        else if (stall_cnt_q == LAST) stall_cnt_q <= '0;
        else                          stall_cnt_q <= stall_cnt_q + 1'b1;
      end

      assign stall_cycle = (stall_cnt_q == LAST);
    end
  endgenerate

  // Storage is never reset; the read below sees the pre-edge word, which
  // gives read-before-write against a same-cycle preload.
  always_ff @(posedge clk_i) begin
    if (load_we_i) mem_q[load_addr_i] <= load_wdata_i;
  end

  always_comb begin
    resp_in       = '0;
    resp_in.valid = instr_gnt_o;
    resp_in.err   = !in_range;
    resp_in.data  = in_range ? mem_q[word_off[IW-1:0]] : ERR_WORD;
  end

  mem_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .resp_i (resp_in),
    .resp_o (resp_out)
  );

  assign instr_rvalid_o = resp_out.valid;
  assign instr_rdata_o  = resp_out.data;
  assign instr_err_o    = resp_out.err;

  always_comb begin
    out_d = out_q;
    if (instr_gnt_o && !instr_rvalid_o)      out_d = out_q + 1'b1;
    else if (!instr_gnt_o && instr_rvalid_o) out_d = out_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      busy_q <= (out_d != '0);
    end
  end

  assign busy_o = busy_q;

  assert property (@(posedge clk_i) disable iff (rst_i)
                   !(instr_rvalid_o && !instr_gnt_o && out_q == '0));
  assert property (@(posedge clk_i) disable iff (rst_i) out_q <= MAX_Q);

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - directed self-checking bench for instr_mem_responder
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        load_we = 1'b0;
  logic [5:0]  load_addr = 6'd0;
  logic [31:0] load_wdata = 32'h0;

  logic        u1_gnt, u1_rvalid, u1_err, u1_busy;
  logic [31:0] u1_rdata;
  logic        u3_gnt, u3_rvalid, u3_err, u3_busy;
  logic [31:0] u3_rdata;
  logic        us_gnt, us_rvalid, us_err, us_busy;
  logic [31:0] us_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.MEM_WORDS(64), .LATENCY(1), .MAX_OUTSTANDING(2), .STALL_PERIOD(0)) u1 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(u1_gnt), .instr_rvalid_o(u1_rvalid), .instr_rdata_o(u1_rdata),
    .instr_err_o(u1_err), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_wdata_i(load_wdata), .busy_o(u1_busy));

  instr_mem_responder #(.MEM_WORDS(64), .LATENCY(3), .MAX_OUTSTANDING(2), .STALL_PERIOD(0)) u3 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(u3_gnt), .instr_rvalid_o(u3_rvalid), .instr_rdata_o(u3_rdata),
    .instr_err_o(u3_err), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_wdata_i(load_wdata), .busy_o(u3_busy));

  instr_mem_responder #(.MEM_WORDS(64), .LATENCY(1), .MAX_OUTSTANDING(2), .STALL_PERIOD(3)) us (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(us_gnt), .instr_rvalid_o(us_rvalid), .instr_rdata_o(us_rdata),
    .instr_err_o(us_err), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_wdata_i(load_wdata), .busy_o(us_busy));

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; load_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_wdata = d;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; addr = 32'h8000;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (u1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", u1_gnt); end
    n_checks++; if (u1_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", u1_rvalid); end
    n_checks++; if (u1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", u1_rdata); end
    n_checks++; if (u1_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", u1_err); end
    n_checks++; if (u3_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", u3_busy); end
    do_reset();
  endtask

  task automatic test_single_fetch();
    do_reset();
    preload(6'd0, 32'h0000_0013);
    req = 1'b1; addr = 32'h8000;
    @(negedge clk);
    n_checks++; if (u1_gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b expected 1", u1_gnt); end
    n_checks++; if (u1_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_early_rvalid: got %b expected 0", u1_rvalid); end
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk);
    n_checks++; if (u1_rvalid !== 1'b1) begin n_fail++; $display("FAIL single_rvalid: got %b expected 1", u1_rvalid); end
    n_checks++; if (u1_rdata !== 32'h13) begin n_fail++; $display("FAIL single_rdata: got %h expected 00000013", u1_rdata); end
    n_checks++; if (u1_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", u1_err); end
  endtask

  task automatic test_back_to_back();
    bit          e_gnt  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit          e_rv   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit          e_busy [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] e_data [5] = '{32'h0, 32'h13, 32'h1111_0001, 32'h2222_0002, 32'h2222_0002};
    do_reset();
    preload(6'd1, 32'h1111_0001);
    preload(6'd2, 32'h2222_0002);
    for (int i = 0; i < 5; i++) begin
      req = (i < 3); addr = 32'h8000 + 32'(4 * i);
      @(negedge clk);
      n_checks++; if (u1_gnt !== e_gnt[i]) begin n_fail++; $display("FAIL b2b_gnt c%0d: got %b expected %b", i, u1_gnt, e_gnt[i]); end
      n_checks++; if (u1_rvalid !== e_rv[i]) begin n_fail++; $display("FAIL b2b_rvalid c%0d: got %b expected %b", i, u1_rvalid, e_rv[i]); end
      n_checks++; if (u1_busy !== e_busy[i]) begin n_fail++; $display("FAIL b2b_busy c%0d: got %b expected %b", i, u1_busy, e_busy[i]); end
      if (i > 0) begin
        n_checks++; if (u1_rdata !== e_data[i]) begin n_fail++; $display("FAIL b2b_rdata c%0d: got %h expected %h", i, u1_rdata, e_data[i]); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_outstanding_limit();
    bit          e_gnt  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit          e_rv   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] e_data [6] = '{32'h0, 32'h0, 32'h0, 32'h13, 32'h1111_0001, 32'h0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req = 1'b1; addr = 32'h8000 + 32'(4 * i);
      @(negedge clk);
      n_checks++; if (u3_gnt !== e_gnt[i]) begin n_fail++; $display("FAIL limit_gnt c%0d: got %b expected %b", i, u3_gnt, e_gnt[i]); end
      n_checks++; if (u3_rvalid !== e_rv[i]) begin n_fail++; $display("FAIL limit_rvalid c%0d: got %b expected %b", i, u3_rvalid, e_rv[i]); end
      if (e_rv[i]) begin
        n_checks++; if (u3_rdata !== e_data[i]) begin n_fail++; $display("FAIL limit_rdata c%0d: got %h expected %h", i, u3_rdata, e_data[i]); end
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [31:0] a_vec  [4] = '{32'h0000_0000, 32'h0000_8100, 32'h0000_80FC, 32'h0000_7FFC};
    bit          e_rv   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] e_data [5] = '{32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h3F, 32'hDEAD_BEEF};
    bit          e_err  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    preload(6'd63, 32'h0000_003F);
    for (int i = 0; i < 5; i++) begin
      req = (i < 4); addr = (i < 4) ? a_vec[i] : 32'h8000;
      @(negedge clk);
      if (i < 4) begin
        n_checks++; if (u1_gnt !== 1'b1) begin n_fail++; $display("FAIL oor_gnt c%0d: got %b expected 1", i, u1_gnt); end
      end
      n_checks++; if (u1_rvalid !== e_rv[i]) begin n_fail++; $display("FAIL oor_rvalid c%0d: got %b expected %b", i, u1_rvalid, e_rv[i]); end
      if (e_rv[i]) begin
        n_checks++; if (u1_rdata !== e_data[i]) begin n_fail++; $display("FAIL oor_rdata c%0d: got %h expected %h", i, u1_rdata, e_data[i]); end
        n_checks++; if (u1_err !== e_err[i]) begin n_fail++; $display("FAIL oor_err c%0d: got %b expected %b", i, u1_err, e_err[i]); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_flight();
    bit e_rv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    req = 1'b1; addr = 32'h8000;
    @(posedge clk); #1; addr = 32'h8004;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (u3_rvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_rvalid: got %b expected 1", u3_rvalid); end
    rst = 1'b1; req = 1'b1; addr = 32'h8000;
    #1;
    n_checks++; if (u3_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_async_rvalid: got %b expected 0", u3_rvalid); end
    n_checks++; if (u3_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_async_rdata: got %h expected 0", u3_rdata); end
    n_checks++; if (u3_gnt !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt_in_reset: got %b expected 0", u3_gnt); end
    n_checks++; if (u3_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", u3_busy); end
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_checks++; if (u3_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_first_gnt: got %b expected 1", u3_gnt); end
      end
      n_checks++; if (u3_rvalid !== e_rv[k]) begin n_fail++; $display("FAIL midrst_rvalid c%0d: got %b expected %b", k, u3_rvalid, e_rv[k]); end
      if (e_rv[k]) begin
        n_checks++; if (u3_rdata !== 32'h13) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 00000013", u3_rdata); end
      end
      @(posedge clk); #1; req = 1'b0;
    end
  endtask

  task automatic test_preload_collision();
    do_reset();
    preload(6'd5, 32'h0505_0505);
    load_we = 1'b1; load_addr = 6'd5; load_wdata = 32'hA5A5_A5A5;
    req = 1'b1; addr = 32'h8014;
    @(negedge clk);
    n_checks++; if (u1_gnt !== 1'b1) begin n_fail++; $display("FAIL coll_gnt: got %b expected 1", u1_gnt); end
    @(posedge clk); #1; load_we = 1'b0;
    @(negedge clk);
    n_checks++; if (u1_rvalid !== 1'b1) begin n_fail++; $display("FAIL coll_rvalid_old: got %b expected 1", u1_rvalid); end
    n_checks++; if (u1_rdata !== 32'h0505_0505) begin n_fail++; $display("FAIL coll_old_data: got %h expected 05050505", u1_rdata); end
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk);
    n_checks++; if (u1_rvalid !== 1'b1) begin n_fail++; $display("FAIL coll_rvalid_new: got %b expected 1", u1_rvalid); end
    n_checks++; if (u1_rdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL coll_new_data: got %h expected a5a5a5a5", u1_rdata); end
  endtask

  task automatic test_stall();
    bit e_gnt [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit e_rv  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req = 1'b1; addr = 32'h8000;
      @(negedge clk);
      n_checks++; if (us_gnt !== e_gnt[i]) begin n_fail++; $display("FAIL stall_gnt c%0d: got %b expected %b", i, us_gnt, e_gnt[i]); end
      n_checks++; if (us_rvalid !== e_rv[i]) begin n_fail++; $display("FAIL stall_rvalid c%0d: got %b expected %b", i, us_rvalid, e_rv[i]); end
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_outstanding_limit();
    test_out_of_range();
    test_reset_mid_flight();
    test_preload_collision();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
